instruction_stream_tx: RTL

- Transmit-side counterpart of the TPU opcode decoder. Converts queued instructions (opcode plus 32-bit operand) into the byte stream the decoder path consumes.
- Emits one opcode byte, followed by 4 operand bytes only for opcodes that carry operands.
- Sits between the host-side command sequencer and the byte link (UART/FIFO) feeding the TPU front end.
- Buffers instructions in a small FIFO and screens out illegal opcodes.

---
 rtl/instruction_stream_tx.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/instruction_stream_tx.sv
// Serialises queued {opcode, operand} instructions into a byte stream for the TPU decoder path.
// Illegal opcodes are dropped at the queue; operand bytes are sent big-endian after operand-bearing opcodes.
module instruction_stream_tx #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned OPERAND_BYTES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          instr_valid,
  output logic                          instr_ready,
  input  logic [7:0]                    instr_opcode,
  input  logic [31:0]                   instr_operand,
  output logic                          byte_valid,
  input  logic                          byte_ready,
  output logic [7:0]                    byte_data,
  output logic                          byte_last,
  input  logic                          resume,
  output logic                          halted,
  output logic                          err_illegal,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = $clog2(OPERAND_BYTES + 1);
  localparam logic [7:0]  OP_HALT = 8'h3F;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_OPCODE  = 2'd1;
  localparam logic [1:0] S_OPERAND = 2'd2;
  localparam logic [1:0] S_HALTED  = 2'd3;

  function automatic logic is_legal(input logic [7:0] op);
    return op inside {[8'h00:8'h05], [8'h10:8'h12], [8'h18:8'h1B], [8'h20:8'h23],
                      8'h30, 8'h31, 8'h3F};
  endfunction

  function automatic logic has_operand(input logic [7:0] op);
    return op inside {8'h03, 8'h04, 8'h05, 8'h31};
  endfunction

  logic [7:0]    op_mem  [FIFO_DEPTH];
  logic [31:0]   arg_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  logic [1:0]    state_q, state_d;
  logic          valid_q, valid_d;
  logic [7:0]    data_q, data_d;
  logic          last_q, last_d;
  logic          halted_q, halted_d;
  logic          err_q;
  logic [7:0]    opcode_q, opcode_d;
  logic [31:0]   arg_q, arg_d;
  logic [IW-1:0] idx_q, idx_d;

  logic push, pop, fifo_empty, xfer, next_instr;

  assign instr_ready = (count_q < CW'(FIFO_DEPTH));
  assign fifo_empty  = (count_q == '0);
  assign push        = instr_valid & instr_ready & is_legal(instr_opcode);
  assign xfer        = valid_q & byte_ready;

  assign byte_valid  = valid_q;
  assign byte_data   = data_q;
  assign byte_last   = last_q;
  assign halted      = halted_q;
  assign err_illegal = err_q;
  assign fifo_count  = count_q;

  always_ff @(posedge clk) begin
    if (push) begin
      op_mem[wr_ptr_q]  <= instr_opcode;
      arg_mem[wr_ptr_q] <= instr_operand;
    end
  end

  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    data_d     = data_q;
    last_d     = last_q;
    halted_d   = halted_q;
    opcode_d   = opcode_q;
    arg_d      = arg_q;
    idx_d      = idx_q;
    pop        = 1'b0;
    next_instr = 1'b0;

    // arg_q shifts left as bytes go out, so the next operand byte is always arg_q[31:24]
    case (state_q)
      S_IDLE: next_instr = 1'b1;
      S_OPCODE: begin
        if (xfer) begin
          if (has_operand(opcode_q)) begin
            data_d  = arg_q[31:24];
            arg_d   = arg_q << 8;
            idx_d   = IW'(1);
            last_d  = (OPERAND_BYTES == 1);
            state_d = S_OPERAND;
          end else if (opcode_q == OP_HALT) begin
            valid_d  = 1'b0;
            last_d   = 1'b0;
            halted_d = 1'b1;
            state_d  = S_HALTED;
          end else begin
            next_instr = 1'b1;
          end
        end
      end
      S_OPERAND: begin
        if (xfer) begin
          if (idx_q == IW'(OPERAND_BYTES)) begin
            next_instr = 1'b1;
          end else begin
            data_d = arg_q[31:24];
            arg_d  = arg_q << 8;
            idx_d  = idx_q + IW'(1);
            last_d = (idx_q == IW'(OPERAND_BYTES - 1));
          end
        end
      end
      default: begin
        if (resume) begin
          halted_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
    endcase

    // Shared by IDLE and end-of-instruction so back-to-back instructions leave no bubble
    if (next_instr) begin
      if (!fifo_empty) begin
        pop      = 1'b1;
        opcode_d = op_mem[rd_ptr_q];
        arg_d    = arg_mem[rd_ptr_q];
        data_d   = op_mem[rd_ptr_q];
        valid_d  = 1'b1;
        last_d   = !has_operand(op_mem[rd_ptr_q]);
        idx_d    = '0;
        state_d  = S_OPCODE;
      end else begin
        valid_d  = 1'b0;
        last_d   = 1'b0;
        state_d  = S_IDLE;
      end
    end

    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
      opcode_q <= '0;
      arg_q    <= '0;
      idx_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q  <= count_d;
      state_q  <= state_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      last_q   <= last_d;
      halted_q <= halted_d;
      err_q    <= instr_valid & instr_ready & !is_legal(instr_opcode);
      opcode_q <= opcode_d;
      arg_q    <= arg_d;
      idx_q    <= idx_d;
    end
  end

endmodule
